// File: rtl/mem_stage_pkg.sv
// Shared CPU pipeline definitions: bus widths, field offsets, encodings and
// small helpers for the memory stage.
package mem_stage_pkg;

    localparam int unsigned EXE_MEM_W = 80;
    localparam int unsigned MEM_WB_W  = 43;

    // EXE_MEM_BUS = {en, aim, rd, sel, mem_rd, mem_wr, mem_size, mem_sext, alu_result, store_data}
    localparam int unsigned EM_STORE_DATA_LSB = 0;
    localparam int unsigned EM_ALU_RESULT_LSB = 32;
    localparam int unsigned EM_SEXT_BIT       = 64;
    localparam int unsigned EM_SIZE_LSB       = 65;
    localparam int unsigned EM_MEM_WR_BIT     = 67;
    localparam int unsigned EM_MEM_RD_BIT     = 68;
    localparam int unsigned EM_SEL_LSB        = 69;
    localparam int unsigned EM_RD_LSB         = 72;
    localparam int unsigned EM_AIM_LSB        = 77;
    localparam int unsigned EM_EN_BIT         = 79;

    // MEM_WB_BUS = {en, aim, rd, sel, w_data}
    localparam int unsigned WB_DATA_LSB = 0;
    localparam int unsigned WB_SEL_LSB  = 32;
    localparam int unsigned WB_RD_LSB   = 35;
    localparam int unsigned WB_AIM_LSB  = 40;
    localparam int unsigned WB_EN_BIT   = 42;

    typedef enum logic [1:0] {
        AimReg = 2'b00,
        AimLo  = 2'b01,
        AimHi  = 2'b10,
        AimCp0 = 2'b11
    } aim_e;

    typedef enum logic [1:0] {
        SizeByte    = 2'b00,
        SizeHalf    = 2'b01,
        SizeWord    = 2'b10,
        SizeWordAlt = 2'b11
    } mem_size_e;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StWait = 1'b1
    } mem_state_e;

    // Everything needed to drive the data-memory request and retire the op.
    typedef struct packed {
        logic        en;
        aim_e        aim;
        logic [4:0]  rd;
        logic [2:0]  sel;
        logic        we;
        mem_size_e   size;
        logic        sext;
        logic [31:0] alu_result;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } mem_req_t;

    function automatic logic is_misaligned(mem_size_e size, logic [1:0] addr);
        case (size)
            SizeByte: is_misaligned = 1'b0;
            SizeHalf: is_misaligned = addr[0];
            default:  is_misaligned = |addr;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(mem_size_e size, logic [1:0] addr);
        case (size)
            SizeByte: store_strobe = 4'b0001 << addr;
            SizeHalf: store_strobe = addr[1] ? 4'b1100 : 4'b0011;
            default:  store_strobe = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(mem_size_e size, logic [31:0] data);
        case (size)
            SizeByte: store_wdata = {4{data[7:0]}};
            SizeHalf: store_wdata = {2{data[15:0]}};
            default:  store_wdata = data;
        endcase
    endfunction

    function automatic logic [MEM_WB_W-1:0] pack_wb(logic en, aim_e aim, logic [4:0] rd,
                                                    logic [2:0] sel, logic [31:0] data);
        pack_wb                      = '0;
        pack_wb[WB_EN_BIT]           = en;
        pack_wb[WB_AIM_LSB +: 2]     = aim;
        pack_wb[WB_RD_LSB +: 5]      = rd;
        pack_wb[WB_SEL_LSB +: 3]     = sel;
        pack_wb[WB_DATA_LSB +: 32]   = data;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response channel between the memory stage (master)
// and the data memory (slave).
interface mem_stage_if;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req,
        output dm_we,
        output dm_addr,
        output dm_wstrb,
        output dm_wdata,
        input  dm_ack,
        input  dm_rdata
    );

    modport slave (
        input  dm_req,
        input  dm_we,
        input  dm_addr,
        input  dm_wstrb,
        input  dm_wdata,
        output dm_ack,
        output dm_rdata
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load formatter: picks the addressed byte/half lane out of the memory word
// and sign- or zero-extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  mem_size_e   size,
    input  logic        sext,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (size)
            SizeByte: data = {{24{sext & byte_lane[7]}}, byte_lane};
            SizeHalf: data = {{16{sext & half_lane[15]}}, half_lane};
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: passes ALU ops through in one cycle and holds
// aligned loads/stores in WAIT until the data memory acknowledges.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 exe_valid,
    output logic                 mem_allowin,
    input  logic [EXE_MEM_W-1:0] EXE_MEM_BUS,
    mem_stage_if.master          dm,
    output logic                 addr_err,
    output logic [MEM_WB_W-1:0]  MEM_WB_BUS
);

    mem_state_e            state_q, state_d;
    mem_req_t              req_q, req_d;
    logic [MEM_WB_W-1:0]   wb_q, wb_d;
    logic                  addr_err_q, addr_err_d;

    logic        ex_en;
    aim_e        ex_aim;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_sel;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    mem_size_e   ex_size;
    logic        ex_sext;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic        ex_is_mem;
    logic        ex_misaligned;
    logic [31:0] load_data;

    assign ex_en         = EXE_MEM_BUS[EM_EN_BIT];
    assign ex_aim        = aim_e'(EXE_MEM_BUS[EM_AIM_LSB +: 2]);
    assign ex_rd         = EXE_MEM_BUS[EM_RD_LSB +: 5];
    assign ex_sel        = EXE_MEM_BUS[EM_SEL_LSB +: 3];
    assign ex_mem_rd     = EXE_MEM_BUS[EM_MEM_RD_BIT];
    assign ex_mem_wr     = EXE_MEM_BUS[EM_MEM_WR_BIT];
    assign ex_size       = mem_size_e'(EXE_MEM_BUS[EM_SIZE_LSB +: 2]);
    assign ex_sext       = EXE_MEM_BUS[EM_SEXT_BIT];
    assign ex_alu_result = EXE_MEM_BUS[EM_ALU_RESULT_LSB +: 32];
    assign ex_store_data = EXE_MEM_BUS[EM_STORE_DATA_LSB +: 32];

    assign ex_is_mem     = ex_mem_rd | ex_mem_wr;
    assign ex_misaligned = is_misaligned(ex_size, ex_alu_result[1:0]);

    load_align u_load_align (
        .rdata (dm.dm_rdata),
        .addr  (req_q.alu_result[1:0]),
        .size  (req_q.size),
        .sext  (req_q.sext),
        .data  (load_data)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        wb_d       = wb_q;
        // Only a retiring op raises en; every other edge leaves a bubble.
        wb_d[WB_EN_BIT] = 1'b0;
        addr_err_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (exe_valid) begin
                    if (!ex_is_mem) begin
                        wb_d = pack_wb(ex_en, ex_aim, ex_rd, ex_sel, ex_alu_result);
                    end else if (ex_misaligned) begin
                        addr_err_d = 1'b1;
                    end else begin
                        req_d.en         = ex_en;
                        req_d.aim        = ex_aim;
                        req_d.rd         = ex_rd;
                        req_d.sel        = ex_sel;
                        // rd+wr together is treated as a load
                        req_d.we         = ex_mem_wr & ~ex_mem_rd;
                        req_d.size       = ex_size;
                        req_d.sext       = ex_sext;
                        req_d.alu_result = ex_alu_result;
                        req_d.wstrb      = store_strobe(ex_size, ex_alu_result[1:0]);
                        req_d.wdata      = store_wdata(ex_size, ex_store_data);
                        state_d          = StWait;
                    end
                end
            end
            StWait: begin
                if (dm.dm_ack) begin
                    wb_d    = pack_wb(req_q.en, req_q.aim, req_q.rd, req_q.sel,
                                      req_q.we ? req_q.alu_result : load_data);
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            req_q      <= '0;
            wb_q       <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            wb_q       <= wb_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign mem_allowin = (state_q == StIdle);
    assign addr_err    = addr_err_q;
    assign MEM_WB_BUS  = wb_q;

    assign dm.dm_req   = (state_q == StWait);
    assign dm.dm_we    = req_q.we;
    assign dm.dm_addr  = {req_q.alu_result[31:2], 2'b00};
    assign dm.dm_wstrb = req_q.wstrb;
    assign dm.dm_wdata = req_q.wdata;

endmodule
